// File: rtl/keyboard_highlight_engine.sv
// rtl/keyboard_highlight_engine.sv - pipelined N-key piano renderer with per-key fading highlight levels
module keyboard_highlight_engine #(
  parameter int NUM_KEYS    = 12,
  parameter int NUM_VOICES  = 4,
  parameter int KEY_W       = 8,
  parameter int KB_X0       = 0,
  parameter int KB_Y0       = 180,
  parameter int KB_Y1       = 479,
  parameter int BLACK_Y1    = 397,
  parameter int WHITE_SHIFT = 6,
  parameter int BLACK_W     = 44,
  parameter int LVL_W       = 3
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_clk,
  input  logic [NUM_VOICES*KEY_W-1:0] notes,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  output logic [KEY_W-1:0]            key_id,
  output logic                        is_black,
  output logic                        border,
  output logic [LVL_W-1:0]            level
);

  localparam int XW        = 1 << WHITE_SHIFT;
  localparam int HALF_B    = BLACK_W / 2;
  // Enough subtract-7 steps to reduce the largest possible white index
  localparam int OCT_ITERS = ((1024 >> WHITE_SHIFT) + 6) / 7;

  localparam logic [9:0]             X0      = 10'(KB_X0);
  localparam logic [9:0]             Y0      = 10'(KB_Y0);
  localparam logic [9:0]             Y1      = 10'(KB_Y1);
  localparam logic [9:0]             BY1     = 10'(BLACK_Y1);
  localparam logic [WHITE_SHIFT-1:0] XO_BL   = WHITE_SHIFT'(XW - HALF_B);
  localparam logic [WHITE_SHIFT-1:0] XO_BR   = WHITE_SHIFT'(HALF_B);
  localparam logic [WHITE_SHIFT-1:0] XO_BLST = WHITE_SHIFT'(HALF_B - 1);
  localparam logic [LVL_W-1:0]       LVL_MAX = '1;

  // Semitone offset of each white key within an octave (C D E F G A B)
  function automatic logic [3:0] white_off(input logic [2:0] pp);
    case (pp)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      default: return 4'd11;
    endcase
  endfunction

  // A black key sits to the right of C, D, F, G and A
  function automatic logic black_right(input logic [2:0] pp);
    return (pp == 3'd0) || (pp == 3'd1) || (pp == 3'd3) || (pp == 3'd4) || (pp == 3'd5);
  endfunction

  logic sync0, sync1, sync_d;
  logic tick;

  // Bring the frame strobe into the Clk domain and remember the last level for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync0  <= frame_clk;
      sync1  <= sync0;
      sync_d <= sync1;
    end
  end

  assign tick = sync1 & ~sync_d;

  logic [NUM_KEYS:1] held;

  // A key is held when any voice carries its number; 0 and out-of-range notes match nothing
  always_comb begin
    held = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      for (int k = 1; k <= NUM_KEYS; k++) begin
        if (notes[v*KEY_W +: KEY_W] == KEY_W'(k)) held[k] = 1'b1;
      end
    end
  end

  logic [LVL_W-1:0] lvl [1:NUM_KEYS];

  // Held keys jump to full brightness; released keys fade one step per frame and stop at 0
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 1; k <= NUM_KEYS; k++) lvl[k] <= '0;
    end else begin
      for (int k = 1; k <= NUM_KEYS; k++) begin
        if (held[k])                     lvl[k] <= LVL_MAX;
        else if (tick && lvl[k] != '0)   lvl[k] <= lvl[k] - 1'b1;
      end
    end
  end

  logic [9:0]             dx, w0, rem, oct0;
  logic [WHITE_SHIFT-1:0] xo0;
  logic [2:0]             p0;

  // Split the pixel column into white-key index, offset within the key, octave and position in octave
  always_comb begin
    dx   = DrawX - X0;
    w0   = dx >> WHITE_SHIFT;
    xo0  = dx[WHITE_SHIFT-1:0];
    rem  = w0;
    oct0 = '0;
    for (int i = 0; i < OCT_ITERS; i++) begin
      if (rem >= 10'd7) begin
        rem  = rem - 10'd7;
        oct0 = oct0 + 10'd1;
      end
    end
    p0 = rem[2:0];
  end

  logic [9:0]             s1_x, s1_y, s1_w, s1_oct;
  logic [WHITE_SHIFT-1:0] s1_xo;
  logic [2:0]             s1_p;

  // Stage 1: capture the pixel and its geometry
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_x   <= '0;
      s1_y   <= '0;
      s1_w   <= '0;
      s1_xo  <= '0;
      s1_p   <= '0;
      s1_oct <= '0;
    end else begin
      s1_x   <= DrawX;
      s1_y   <= DrawY;
      s1_w   <= w0;
      s1_xo  <= xo0;
      s1_p   <= p0;
      s1_oct <= oct0;
    end
  end

  // Key numbers are kept one bit wider than pixel math so large octaves cannot wrap into range
  logic [10:0]      ws, key_c;
  logic [2:0]       pm1;
  logic             in_kb, upper, blk_c, brd_c;
  logic [LVL_W-1:0] lvl_c;

  // Classify the stage-1 pixel as background, black key or white key and pick up that key's level
  always_comb begin
    ws    = 11'(s1_oct) * 11'd12 + 11'(white_off(s1_p)) + 11'd1;
    pm1   = (s1_p == 3'd0) ? 3'd6 : s1_p - 3'd1;
    in_kb = (s1_x >= X0) && (s1_y >= Y0) && (s1_y <= Y1);
    upper = (s1_y <= BY1);
    key_c = '0;
    blk_c = 1'b0;
    brd_c = 1'b0;
    if (in_kb) begin
      if (upper && s1_xo >= XO_BL && black_right(s1_p)) begin
        key_c = ws + 11'd1;
        blk_c = 1'b1;
        brd_c = (s1_xo == XO_BL) || (s1_y == Y0) || (s1_y == BY1);
      end else if (upper && s1_xo < XO_BR && s1_w != '0 && black_right(pm1)) begin
        key_c = ws - 11'd1;
        blk_c = 1'b1;
        brd_c = (s1_xo == XO_BLST) || (s1_y == Y0) || (s1_y == BY1);
      end else begin
        key_c = ws;
        brd_c = (s1_xo == '0) || (s1_y == Y0);
      end
    end
    if (key_c > 11'(NUM_KEYS)) begin
      key_c = '0;
      blk_c = 1'b0;
      brd_c = 1'b0;
    end
    lvl_c = '0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      if (key_c == 11'(k)) lvl_c = lvl[k];
    end
  end

  // Stage 2: register the pixel's key, shape and current brightness
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_id   <= '0;
      is_black <= 1'b0;
      border   <= 1'b0;
      level    <= '0;
    end else begin
      key_id   <= KEY_W'(key_c);
      is_black <= blk_c;
      border   <= brd_c;
      level    <= lvl_c;
    end
  end

endmodule

// File: tb/tb_keyboard_highlight_engine.sv
// tb/tb_keyboard_highlight_engine.sv - directed vector bench for keyboard_highlight_engine
module tb_keyboard_highlight_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [31:0] notes_a = '0;
  logic [63:0] notes_b = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;

  logic [7:0]  key_a, key_b;
  logic        blk_a, blk_b, brd_a, brd_b;
  logic [2:0]  lvl_a;
  logic [3:0]  lvl_b;

  keyboard_highlight_engine u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .notes(notes_a),
    .DrawX(DrawX), .DrawY(DrawY),
    .key_id(key_a), .is_black(blk_a), .border(brd_a), .level(lvl_a)
  );

  keyboard_highlight_engine #(.NUM_KEYS(25), .NUM_VOICES(8), .LVL_W(4)) u_big (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .notes(notes_b),
    .DrawX(DrawX), .DrawY(DrawY),
    .key_id(key_b), .is_black(blk_b), .border(brd_b), .level(lvl_b)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         key;
    int         blk;
    int         brd;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic show(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step(2);
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    step(4);
    frame_clk = 1'b0;
    step(4);
  endtask

  task automatic add(input int x, input int y, input int k, input int b, input int br);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.key = k; v.blk = b; v.brd = br;
    vq.push_back(v);
  endtask

  initial begin
    add(10, 300, 1, 0, 0);
    add(60, 250, 2, 1, 0);
    add(70, 420, 3, 0, 0);
    add(180, 250, 5, 0, 0);
    add(200, 250, 6, 0, 0);
    add(0, 300, 1, 0, 1);
    add(10, 170, 0, 0, 0);
    add(42, 250, 2, 1, 1);
    add(85, 250, 2, 1, 1);
    add(86, 250, 3, 0, 0);
    add(60, 180, 2, 1, 1);
    add(60, 397, 2, 1, 1);
    add(60, 398, 1, 0, 0);
    add(10, 479, 1, 0, 0);
    add(10, 480, 0, 0, 0);
    add(370, 250, 11, 1, 0);
    add(447, 300, 12, 0, 0);
    add(448, 300, 0, 0, 0);

    // reset with random activity on every input
    for (int i = 0; i < 4; i++) begin
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      notes_a = $urandom; notes_b = {$urandom, $urandom};
      frame_clk = 1'($urandom);
      step(1);
      chk("rst_out_a", int'({key_a, blk_a, brd_a, lvl_a}), 0);
      chk("rst_out_b", int'({key_b, blk_b, brd_b, lvl_b}), 0);
    end
    notes_a = '0; notes_b = '0; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
    step(1);
    Reset_n = 1'b1;
    step(2);
    show(70, 420);
    chk("idle_lvl_k3", int'(lvl_a), 0);

    // streamed geometry table, one pixel per clock
    for (int i = 0; i < vq.size() + 2; i++) begin
      @(negedge Clk);
      if (i >= 2) begin
        chk($sformatf("tbl%0d_key", i - 2), int'(key_a), vq[i-2].key);
        chk($sformatf("tbl%0d_blk", i - 2), int'(blk_a), vq[i-2].blk);
        chk($sformatf("tbl%0d_brd", i - 2), int'(brd_a), vq[i-2].brd);
        chk($sformatf("tbl%0d_lvl", i - 2), int'(lvl_a), 0);
      end
      if (i < vq.size()) begin
        DrawX = vq[i].x;
        DrawY = vq[i].y;
      end
    end

    // multiple voices, including a duplicate
    notes_a = {8'd0, 8'd5, 8'd5, 8'd12};
    step(1);
    show(180, 420); chk("mv_lvl_k5", int'(lvl_a), 7);
    show(416, 420); chk("mv_key_k12", int'(key_a), 12); chk("mv_lvl_k12", int'(lvl_a), 7);
    show(70, 420);  chk("mv_lvl_k3", int'(lvl_a), 0);
    show(10, 420);  chk("mv_lvl_k1", int'(lvl_a), 0);

    // out-of-range note lights nothing
    notes_a = {24'd0, 8'd20};
    step(1);
    show(288, 420); chk("oor_key_k8", int'(key_a), 8); chk("oor_lvl_k8", int'(lvl_a), 0);
    show(180, 420); chk("oor_lvl_k5", int'(lvl_a), 7);

    // fade of key 3
    notes_a = 32'd3;
    step(1);
    show(70, 420); chk("fade_held", int'(lvl_a), 7);
    notes_a = '0;
    step(2);
    chk("fade_released", int'(lvl_a), 7);
    for (int t = 1; t <= 8; t++) begin
      pulse_frame();
      chk($sformatf("fade_tick%0d", t), int'(lvl_a), (t <= 7) ? 7 - t : 0);
    end

    // re-press in the same cycle as a tick
    notes_a = 32'd3;
    step(2);
    notes_a = '0;
    for (int t = 0; t < 5; t++) pulse_frame();
    chk("repress_pre", int'(lvl_a), 2);
    frame_clk = 1'b1;
    step(2);
    notes_a = 32'd3;
    step(1);
    notes_a = '0;
    step(2);
    frame_clk = 1'b0;
    step(3);
    chk("repress_tick", int'(lvl_a), 7);

    // reset mid-fade on key 8
    notes_a = 32'd8;
    step(2);
    notes_a = '0;
    for (int t = 0; t < 3; t++) pulse_frame();
    show(288, 420);
    chk("midrst_pre_lvl", int'(lvl_a), 4);
    Reset_n = 1'b0;
    #1;
    chk("midrst_out", int'({key_a, blk_a, brd_a, lvl_a}), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(1);
    chk("midrst_1clk_key", int'(key_a), 0);
    step(1);
    chk("midrst_2clk_key", int'(key_a), 8);
    chk("midrst_2clk_lvl", int'(lvl_a), 0);

    // wider build: 25 keys, 8 voices, 4-bit levels
    show(448, 250); chk("big_w7x0_key", int'(key_b), 13); chk("big_w7x0_brd", int'(brd_b), 1);
    show(453, 250); chk("big_w7x5_key", int'(key_b), 13); chk("big_w7x5_brd", int'(brd_b), 0);
    show(958, 250); chk("big_w14x62_key", int'(key_b), 0);
    show(901, 250); chk("big_w14x5_key", int'(key_b), 25);
    notes_b = {8'd25, 56'd0};
    step(2);
    chk("big_held_lvl", int'(lvl_b), 15);
    notes_b = '0;
    for (int t = 0; t < 14; t++) pulse_frame();
    chk("big_fade14", int'(lvl_b), 1);
    pulse_frame();
    chk("big_fade15", int'(lvl_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
